// File: rtl/shift_ctrl_pkg.sv
// Shared types and constants for the shift_ctrl serial sequencer.
package shift_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;
endpackage

// File: rtl/shift_core.sv
// Full-duplex shift register: parallel load, then shift out while capturing si.
// Direction: MSB-first by default, LSB-first with SHIFT_CTRL_LSB_FIRST_EN.
module shift_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             si,
    output logic             so,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_data;
        end else if (shift) begin
`ifdef SHIFT_CTRL_LSB_FIRST_EN
            q_d = {si, q_q[WIDTH-1:1]};
`else
            q_d = {q_q[WIDTH-2:0], si};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q = q_q;
`ifdef SHIFT_CTRL_LSB_FIRST_EN
    assign so = q_q[0];
`else
    assign so = q_q[WIDTH-1];
`endif
endmodule

// File: rtl/shift_ctrl.sv
// Round-robin arbiter + sequencer sharing one serial shift path between requesters A and B.
// Bit order is selected by SHIFT_CTRL_LSB_FIRST_EN (see shift_core).
module shift_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    input  logic             si,
    output logic             so,
    output logic             shift_en,
    output logic             busy,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    input  logic             rsp_ready
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t          state_d, state_q;
    logic [CW-1:0]   cnt_d, cnt_q;
    logic            ptr_d, ptr_q;
    logic            id_d, id_q;
    logic            grant_a, grant_b;
    logic            load, shift;
    logic            core_so;
    logic [WIDTH-1:0] core_q;

    always_comb begin
        grant_a = a_valid && (!b_valid || ptr_q == ID_A);
        grant_b = b_valid && (!a_valid || ptr_q == ID_B);
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_a || grant_b) begin
                    load    = 1'b1;
                    id_d    = grant_b ? ID_B : ID_A;
                    ptr_d   = grant_b ? ID_A : ID_B;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= ID_A;
            id_q    <= ID_A;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
        end
    end

    shift_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (grant_b ? b_data : a_data),
        .shift     (shift),
        .si        (si),
        .so        (core_so),
        .q         (core_q)
    );

    // Ready is combinational so a requester is accepted in the same IDLE cycle it asserts valid.
    assign a_ready   = (state_q == IDLE) && grant_a;
    assign b_ready   = (state_q == IDLE) && grant_b;
    assign shift_en  = (state_q == SHIFT);
    assign so        = shift_en && core_so;
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = core_q;
    assign rsp_id    = id_q;
endmodule

// File: tb/tb_shift_ctrl.sv
// Directed bench for shift_ctrl with a response scoreboard queue.
module tb_shift_ctrl;
    localparam int W = 4;
    localparam logic IDA = 1'b0;
    localparam logic IDB = 1'b1;

    logic         clk = 1'b0;
    logic         rst;
    logic         a_valid, b_valid, si, rsp_ready;
    logic [W-1:0] a_data, b_data;
    logic         a_ready, b_ready, so, shift_en, busy, rsp_valid, rsp_id;
    logic [W-1:0] rsp_data;

    int n_vec = 0;
    int n_err = 0;
    logic [W:0] sb_q[$];

    shift_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .si(si), .so(so), .shift_en(shift_en), .busy(busy),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] capture(input logic [W-1:0] si_bits);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
`ifdef SHIFT_CTRL_LSB_FIRST_EN
            r[i] = si_bits[i];
`else
            r[W-1-i] = si_bits[i];
`endif
        end
        return r;
    endfunction

    function automatic logic so_bit(input logic [W-1:0] d, input int i);
`ifdef SHIFT_CTRL_LSB_FIRST_EN
        return d[i];
`else
        return d[W-1-i];
`endif
    endfunction

    // Caller drives valid/data; this checks grant, shift stream and response.
    task automatic do_xfer(input logic id, input logic [W-1:0] data,
                           input logic [W-1:0] si_bits, input int stall, input bit keep);
        logic [W:0]   exp;
        logic [W-1:0] held;
        rsp_ready = (stall == 0);
        #1;
        chk("a_ready_grant", a_ready, id == IDA);
        chk("b_ready_grant", b_ready, id == IDB);
        sb_q.push_back({id, capture(si_bits)});
        tick();
        if (!keep) begin a_valid = 0; b_valid = 0; end
        for (int i = 0; i < W; i++) begin
            si = si_bits[i];
            #1;
            chk("shift_en", shift_en, 1);
            chk("so_bit", so, so_bit(data, i));
            chk("busy_shift", busy, 1);
            chk("rdy_in_shift", {a_ready, b_ready}, 0);
            chk("no_rsp_in_shift", rsp_valid, 0);
            tick();
        end
        si = 0;
        chk("rsp_valid", rsp_valid, 1);
        chk("resp_so", {so, shift_en}, 0);
        chk("busy_resp", busy, 1);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            exp = sb_q.pop_front();
            chk("rsp_data", rsp_data, exp[W-1:0]);
            chk("rsp_id", rsp_id, exp[W]);
        end
        held = rsp_data;
        for (int s = 0; s < stall; s++) begin
            tick();
            chk("stall_valid", rsp_valid, 1);
            chk("stall_data", rsp_data, held);
            chk("stall_rdy", {a_ready, b_ready}, 0);
        end
        rsp_ready = 1;
        tick();
        chk("idle_after_rsp", {busy, rsp_valid}, 0);
    endtask

    initial begin
        rst = 1; a_valid = 0; b_valid = 0; a_data = 0; b_data = 0; si = 0; rsp_ready = 0;
        tick(); tick();
        rst = 0;
        #1;
        chk("reset_outs", {so, shift_en, busy, rsp_valid, rsp_id, a_ready, b_ready}, 0);
        chk("reset_data", rsp_data, 0);

        // A sends 1011, si = 0,1,1,0
        a_valid = 1; a_data = 4'b1011;
        do_xfer(IDA, 4'b1011, 4'b0110, 0, 0);

        // stalled response, A held valid then accepted right after handshake
        a_valid = 1; a_data = 4'hC;
        do_xfer(IDA, 4'hC, 4'b1001, 3, 1);
        a_data = 4'h3;
        do_xfer(IDA, 4'h3, 4'b0011, 0, 0);

        // B valid alone for one cycle
        b_valid = 1; b_data = 4'h9;
        do_xfer(IDB, 4'h9, 4'b1110, 0, 0);

        // both valid: pointer at A, strict alternation
        a_valid = 1; b_valid = 1; a_data = 4'hA; b_data = 4'h5;
        for (int k = 0; k < 5; k++) begin
            logic [W-1:0] sb;
            sb = W'(k + 3);
            do_xfer((k % 2) ? IDB : IDA, (k % 2) ? 4'h5 : 4'hA, sb, 0, 1);
        end
        a_valid = 0; b_valid = 0; rsp_ready = 0;

        // reset on 2nd SHIFT cycle; pointer names B before the reset
        a_valid = 1; a_data = 4'hF;
        #1;
        chk("rst_test_accept", a_ready, 1);
        tick();
        a_valid = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        chk("abort_outs", {so, shift_en, busy, rsp_valid}, 0);
        for (int c = 0; c < W + 2; c++) begin
            tick();
            chk("abort_no_rsp", rsp_valid, 0);
        end
        a_valid = 1; b_valid = 1; a_data = 4'h6; b_data = 4'h2;
        do_xfer(IDA, 4'h6, 4'b0101, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
